tour_cmd: RTL
=============

Name: tour_cmd

Overview:
- Downstream consumer of the knight's-tour solver.
- After the solver reports done, walks its 24-entry move list by driving mv_indx and reading move back.
- Splits each one-hot knight move into two robot motion commands: vertical leg first, then horizontal leg.
- Multiplexes these tour commands with UART-sourced commands into the single command interface of the command processor.

Parameters:
- NUM_MOVES, 24, number of moves in a completed 5x5 tour; last index is NUM_MOVES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_tour  in  1  one-cycle pulse; solver has finished, tour may begin
- move  in  8  one-hot move read from solver at mv_indx (combinational from solver)
- mv_indx  out  5  index of move currently being executed
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to UART wrapper
- cmd  out  16  command to command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has accepted cmd
- send_resp  in  1  command processor finished executing current cmd
- resp  out  8  response byte to UART

Behaviour:
- Command format:
  - [15:12] opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - [11:4] heading: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - [3:0] squares, unsigned magnitude.
- Move decode (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
  - Non-one-hot move decodes to (0,0).
- Vertical cmd: opcode 4'h2; heading north if dy>0, else south; squares |dy|.
- Horizontal cmd: opcode 4'h3; heading east if dx>0, else west; squares |dx|.
- Zero-magnitude legs are still issued (heading north/east, squares 0).
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- IDLE:
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour -> VERT, mv_indx<=0.
- VERT:
  - cmd=vertical cmd, cmd_rdy=1.
  - clr_cmd_rdy -> WAIT_V.
- WAIT_V:
  - cmd_rdy=0.
  - send_resp -> HORZ.
- HORZ:
  - cmd=horizontal cmd, cmd_rdy=1.
  - clr_cmd_rdy -> WAIT_H.
- WAIT_H:
  - cmd_rdy=0.
  - On send_resp: if mv_indx==NUM_MOVES-1 -> IDLE; else mv_indx<=mv_indx+1 -> VERT.
- In every non-IDLE state, clr_cmd_rdy_UART=0 and cmd_rdy_UART is ignored; UART commands wait until IDLE.
- resp:
  - 8'h5A while state!=IDLE, except on the final send_resp cycle in WAIT_H.
  - 8'hA5 in IDLE and on that final send_resp.
  - Combinational from state, mv_indx and send_resp.
- Latency:
  - cmd_rdy high the cycle after start_tour.
  - Next VERT cmd_rdy high the cycle after send_resp in WAIT_H.
- Boundaries:
  - start_tour outside IDLE is ignored.
  - send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
  - clr_cmd_rdy in WAIT states is ignored.
  - clr_cmd_rdy and send_resp in the same cycle in VERT: only the clr takes effect.
  - mv_indx never exceeds NUM_MOVES-1.
- Reset (any state): state=IDLE, mv_indx=0.
  - Outputs then follow IDLE passthrough: cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- Tour cmd and cmd_rdy are registered from state and mv_indx; move is sampled combinationally each cycle.

Decomposition:
- Package tour_pkg holds:
  - opcode constants (OP_MOVE, OP_FANFARE)
  - heading constants (HDG_N/W/S/E)
  - RESP_ACK=8'hA5, RESP_POS=8'h5A
  - state_t enum
  - one-hot move constants
- One combinational sub-module, knight_move_decode: move[7:0] -> vert_cmd[15:0], horz_cmd[15:0].

Test Plan:
- Reset, then cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1; resp=8'hA5.
- start_tour, move=8'h01, mv_indx=0 -> cmd=16'h2002 (north 2) with cmd_rdy=1; after clr and send_resp -> cmd=16'h3BF1 (east 1).
- move=8'h08 -> cmd=16'h27F1 (south 1), then 16'h33F2 (west 2).
- Run all 24 moves with a responder -> mv_indx goes 0..23; resp=8'h5A on each of the first 47 send_resp pulses, 8'hA5 on the 48th; state returns to IDLE.
- Mid-tour: assert cmd_rdy_UART and pulse start_tour -> both ignored, mv_indx unchanged; assert rst in WAIT_H -> next cycle state IDLE, mv_indx=0, cmd passes cmd_UART.
- move=8'h03 (illegal) -> cmd=16'h2000, then 16'h3BF0; tour continues.

Source files
------------

// File: rtl/tour_pkg.sv
// Shared constants and types for the tour command sequencer.
package tour_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    // One-hot knight moves, named by (dx, dy): E/W is x, N/S is y.
    localparam logic [7:0] MV_E1N2 = 8'h01;
    localparam logic [7:0] MV_W1N2 = 8'h02;
    localparam logic [7:0] MV_W2N1 = 8'h04;
    localparam logic [7:0] MV_W2S1 = 8'h08;
    localparam logic [7:0] MV_W1S2 = 8'h10;
    localparam logic [7:0] MV_E1S2 = 8'h20;
    localparam logic [7:0] MV_E2S1 = 8'h40;
    localparam logic [7:0] MV_E2N1 = 8'h80;

    function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [3:0] squares);
        return {op, hdg, squares};
    endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Splits a one-hot knight move into a vertical and a horizontal motion command.
// Anything that is not exactly one of the eight legal moves becomes two
// zero-length legs heading north and east.
module knight_move_decode
    import tour_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic [1:0] x_mag;
    logic [1:0] y_mag;
    logic       x_neg;
    logic       y_neg;

    // Magnitude and sign of each leg for the move.
    always_comb begin
        x_mag = 2'd0;
        y_mag = 2'd0;
        x_neg = 1'b0;
        y_neg = 1'b0;
        case (move)
            MV_E1N2: begin x_mag = 2'd1; y_mag = 2'd2; end
            MV_W1N2: begin x_mag = 2'd1; y_mag = 2'd2; x_neg = 1'b1; end
            MV_W2N1: begin x_mag = 2'd2; y_mag = 2'd1; x_neg = 1'b1; end
            MV_W2S1: begin x_mag = 2'd2; y_mag = 2'd1; x_neg = 1'b1; y_neg = 1'b1; end
            MV_W1S2: begin x_mag = 2'd1; y_mag = 2'd2; x_neg = 1'b1; y_neg = 1'b1; end
            MV_E1S2: begin x_mag = 2'd1; y_mag = 2'd2; y_neg = 1'b1; end
            MV_E2S1: begin x_mag = 2'd2; y_mag = 2'd1; y_neg = 1'b1; end
            MV_E2N1: begin x_mag = 2'd2; y_mag = 2'd1; end
            default: ;
        endcase
    end

    assign vert_cmd = make_cmd(OP_MOVE,    y_neg ? HDG_S : HDG_N, {2'b00, y_mag});
    assign horz_cmd = make_cmd(OP_FANFARE, x_neg ? HDG_W : HDG_E, {2'b00, x_mag});

endmodule

// File: rtl/tour_cmd.sv
// Walks the solver's move list after a completed tour, issuing a vertical then
// a horizontal command per move, and shares the command processor interface
// with the UART command path while idle.
//
// state  | meaning
// IDLE   | UART commands pass straight through; waiting for start_tour
// VERT   | vertical leg of move mv_indx offered to command processor
// WAIT_V | vertical leg accepted, waiting for it to finish executing
// HORZ   | horizontal leg of move mv_indx offered to command processor
// WAIT_H | horizontal leg accepted, waiting for it to finish executing
module tour_cmd
    import tour_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t      state;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        last_move;

    assign last_move = (mv_indx == LAST_INDX);

    knight_move_decode u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    // Sequencing state and move index; the index only advances between moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        state   <= VERT;
                        mv_indx <= '0;
                    end
                end
                VERT:   if (clr_cmd_rdy) state <= WAIT_V;
                WAIT_V: if (send_resp)   state <= HORZ;
                HORZ:   if (clr_cmd_rdy) state <= WAIT_H;
                WAIT_H: begin
                    if (send_resp) begin
                        if (last_move) begin
                            state <= IDLE;
                        end else begin
                            state   <= VERT;
                            mv_indx <= mv_indx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command interface mux: UART passthrough in IDLE, tour legs otherwise.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_POS;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_V: cmd = vert_cmd;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (send_resp && last_move) resp = RESP_ACK;
            end
            default: ;
        endcase
    end

endmodule
